// File: rtl/p2s.sv
// Parallel-to-serial converter: loads an 8-word frame in one handshake and
// emits it d8 first, d1 last, one word per accepted cycle on q.
module p2s #(
   parameter int N = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [2**N-1:0]   d1,
   input  logic [2**N-1:0]   d2,
   input  logic [2**N-1:0]   d3,
   input  logic [2**N-1:0]   d4,
   input  logic [2**N-1:0]   d5,
   input  logic [2**N-1:0]   d6,
   input  logic [2**N-1:0]   d7,
   input  logic [2**N-1:0]   d8,
   output logic [2**N-1:0]   q,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              shift_en,
   output logic              last,
   output logic              busy
);

   localparam int DATA_W = 2**N;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [2:0]        cnt_q, cnt_d;
   logic [2:0]        cnt_inc;
   logic [DATA_W-1:0] frame_q [8];
   logic [DATA_W-1:0] frame_d [8];
   logic [DATA_W-1:0] q_q, q_d;

   logic final_word;
   logic accept;
   logic load;

   // Handshake decode; reset masks both handshakes in the same cycle.
   always_comb begin
      final_word = (state_q == SHIFT) && (cnt_q == 3'd7);
      accept     = (state_q == SHIFT) && out_ready && !rst;
      in_ready   = !rst && ((state_q == IDLE) || (final_word && out_ready));
      load       = in_valid && in_ready;
      cnt_inc    = cnt_q + 3'd1;
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      q_d     = q_q;
      for (int i = 0; i < 8; i++) begin
         frame_d[i] = frame_q[i];
      end

      if (load) begin
         // Slot 0 holds d8 so the emission index is simply cnt.
         frame_d[0] = d8;
         frame_d[1] = d7;
         frame_d[2] = d6;
         frame_d[3] = d5;
         frame_d[4] = d4;
         frame_d[5] = d3;
         frame_d[6] = d2;
         frame_d[7] = d1;
         q_d        = d8;
         cnt_d      = 3'd0;
         state_d    = SHIFT;
      end else if (accept) begin
         if (cnt_q != 3'd7) begin
            cnt_d = cnt_inc;
            q_d   = frame_q[cnt_inc];
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 3'd0;
         q_q     <= '0;
         for (int i = 0; i < 8; i++) begin
            frame_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         q_q     <= q_d;
         for (int i = 0; i < 8; i++) begin
            frame_q[i] <= frame_d[i];
         end
      end
   end

   assign q         = q_q;
   assign out_valid = (state_q == SHIFT);
   assign busy      = (state_q == SHIFT);
   assign last      = final_word;
   assign shift_en  = accept;

endmodule
